mem_stage: RTL and testbench

Memory stage of the in-order pipeline, between EX and WB. It issues load/store/atomic requests to the data cache over a valid/ready request channel and a valid-only response channel. It aligns and sign-extends load data and owns the MEM/WB pipeline register that feeds `wb_stage`. It stalls upstream while an access is outstanding and honours back-pressure and flush from WB.

---
 rtl/mem_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; issues data-cache requests, formats load data, owns MEM/WB.
// Optional feature: define MEM_MISALIGN_CHECK_EN to complete misaligned accesses locally.
package mem_stage_pkg;
  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_csr;
    logic       is_atomic;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       en_rd;
  } decoded_inst_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  decoded_inst_t       inst,
  input  logic                is_bubble,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     rs2_val,
  input  logic [XLEN-1:0]     csr_rdata,
  input  logic                wb_stall,
  input  logic                flush,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic [XLEN-1:0]     dc_req_addr,
  output logic                dc_req_we,
  output logic                dc_req_amo,
  output logic [XLEN-1:0]     dc_req_wdata,
  output logic [XLEN/8-1:0]   dc_req_wstrb,
  input  logic                dc_resp_valid,
  input  logic [XLEN-1:0]     dc_resp_rdata,
  output logic                stall,
  output decoded_inst_t       wb_inst,
  output logic                wb_is_bubble,
  output logic [XLEN-1:0]     wb_alu_result,
  output logic [XLEN-1:0]     wb_mem_result,
  output logic                wb_misaligned
);
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RESP, ST_HOLD, ST_DRAIN} state_t;

  state_t              state, state_nxt;
  logic                mem_op, mem_req, misaligned, complete, hold_load;
  logic [2:0]          off;
  logic [5:0]          lane_sh;
  logic [STRB_W-1:0]   size_mask;
  logic [XLEN-1:0]     lane, load_fmt, hold_buf;
  decoded_inst_t       nxt_inst;
  logic                nxt_bubble, nxt_mis;
  logic [XLEN-1:0]     nxt_mem;

  assign mem_op  = !is_bubble && (inst.is_load || inst.is_store || inst.is_atomic);
  assign mem_req = mem_op && !misaligned;
  assign off     = alu_result[2:0];
  assign lane_sh = {off, 3'b000};

  // Access-size byte mask from funct3[1:0]
  always_comb begin
    case (inst.funct3[1:0])
      2'b00:   size_mask = STRB_W'(1);
      2'b01:   size_mask = STRB_W'(3);
      2'b10:   size_mask = STRB_W'(15);
      default: size_mask = '1;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (inst.funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      2'b11:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Request fields follow the held EX/MEM slot, so they stay stable while waiting for ready
  assign dc_req_addr  = {alu_result[XLEN-1:3], 3'b000};
  assign dc_req_we    = inst.is_store && !inst.is_atomic;
  assign dc_req_amo   = inst.is_atomic;
  assign dc_req_wdata = inst.is_atomic ? rs2_val : (rs2_val << lane_sh);
  assign dc_req_wstrb = (inst.is_store || inst.is_atomic) ? (size_mask << off) : '0;

  // Load lane select and extension
  assign lane = dc_resp_rdata >> lane_sh;
  always_comb begin
    case (inst.funct3)
      3'b000:  load_fmt = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  load_fmt = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  load_fmt = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: load_fmt = lane;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; flush wins, but an accepted request must still be drained
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mem_req) begin
          if (dc_req_ready) state_nxt = flush ? ST_DRAIN : ST_RESP;
          else              state_nxt = flush ? ST_IDLE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (dc_req_ready) state_nxt = flush ? ST_DRAIN : ST_RESP;
        else if (flush)   state_nxt = ST_IDLE;
      end
      ST_RESP: begin
        if (flush)              state_nxt = dc_resp_valid ? ST_IDLE : ST_DRAIN;
        else if (dc_resp_valid) state_nxt = wb_stall ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (flush || !wb_stall) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (dc_resp_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake, stall and MEM/WB next values
  always_comb begin
    dc_req_valid = 1'b0;
    complete     = 1'b0;
    hold_load    = 1'b0;
    nxt_inst     = inst;
    nxt_bubble   = 1'b1;
    nxt_mem      = '0;
    nxt_mis      = 1'b0;
    case (state)
      ST_IDLE: begin
        dc_req_valid = mem_req;
        if (!mem_op) begin
          complete   = 1'b1;
          nxt_bubble = is_bubble;
          nxt_mem    = inst.is_csr ? csr_rdata : '0;
        end else if (misaligned) begin
          complete       = 1'b1;
          nxt_bubble     = 1'b0;
          nxt_mis        = 1'b1;
          nxt_inst.en_rd = 1'b0;
        end
      end
      ST_REQ: dc_req_valid = 1'b1;
      ST_RESP: begin
        if (dc_resp_valid) begin
          complete   = 1'b1;
          nxt_bubble = 1'b0;
          nxt_mem    = load_fmt;
          hold_load  = wb_stall && !flush;
        end
      end
      ST_HOLD: begin
        complete   = 1'b1;
        nxt_bubble = 1'b0;
        nxt_mem    = hold_buf;
      end
      default: ;
    endcase
    if (flush) begin
      nxt_bubble = 1'b1;
      nxt_mis    = 1'b0;
    end
    if (!reset) dc_req_valid = 1'b0;
    stall = wb_stall || (state == ST_REQ) || (state == ST_DRAIN) || (mem_op && !complete);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         hold_buf <= '0;
    else if (hold_load) hold_buf <= load_fmt;
  end

  // MEM/WB pipeline register, frozen by WB back-pressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_inst       <= '0;
      wb_is_bubble  <= 1'b1;
      wb_alu_result <= '0;
      wb_mem_result <= '0;
      wb_misaligned <= 1'b0;
    end else if (!wb_stall) begin
      wb_inst       <= nxt_inst;
      wb_is_bubble  <= nxt_bubble;
      wb_alu_result <= alu_result;
      wb_mem_result <= nxt_mem;
      wb_misaligned <= nxt_mis;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand-written multi-cycle sequences for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          clk, reset;
  decoded_inst_t inst;
  logic          is_bubble;
  logic [63:0]   alu_result, rs2_val, csr_rdata;
  logic          wb_stall, flush;
  logic          dc_req_valid, dc_req_ready, dc_req_we, dc_req_amo;
  logic [63:0]   dc_req_addr, dc_req_wdata;
  logic [7:0]    dc_req_wstrb;
  logic          dc_resp_valid;
  logic [63:0]   dc_resp_rdata;
  logic          stall;
  decoded_inst_t wb_inst;
  logic          wb_is_bubble, wb_misaligned;
  logic [63:0]   wb_alu_result, wb_mem_result;

  int n_pass, n_total;

  mem_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .inst(inst), .is_bubble(is_bubble),
    .alu_result(alu_result), .rs2_val(rs2_val), .csr_rdata(csr_rdata),
    .wb_stall(wb_stall), .flush(flush),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we), .dc_req_amo(dc_req_amo), .dc_req_wdata(dc_req_wdata),
    .dc_req_wstrb(dc_req_wstrb), .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .stall(stall), .wb_inst(wb_inst), .wb_is_bubble(wb_is_bubble),
    .wb_alu_result(wb_alu_result), .wb_mem_result(wb_mem_result), .wb_misaligned(wb_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // kind = {is_load, is_store, is_atomic, is_csr}
  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic [63:0] addr, rs2, rdata, csr;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_wstrb;
    logic        e_we, e_amo;
    logic [63:0] e_mem;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  vec_t v;
  logic is_mem;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] kind, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] rs2);
    inst = '0;
    {inst.is_load, inst.is_store, inst.is_atomic, inst.is_csr} = kind;
    inst.funct3 = f3;
    inst.rd     = 5'd7;
    inst.en_rd  = 1'b1;
    is_bubble   = 1'b0;
    alu_result  = addr;
    rs2_val     = rs2;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    vecs[0]  = '{4'b1000, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 64'h1000, 64'h0, 8'h00, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{4'b1000, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 64'h1000, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0000_0000_0000_0080};
    vecs[2]  = '{4'b1000, 3'b001, 64'h1006, 64'h0, 64'h8123_0000_0000_0000, 64'h0, 64'h1000, 64'h0, 8'h00, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_8123};
    vecs[3]  = '{4'b1000, 3'b101, 64'h1006, 64'h0, 64'h8123_0000_0000_0000, 64'h0, 64'h1000, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0000_0000_0000_8123};
    vecs[4]  = '{4'b1000, 3'b010, 64'h1004, 64'h0, 64'h9876_5432_0000_0000, 64'h0, 64'h1000, 64'h0, 8'h00, 1'b0, 1'b0, 64'hFFFF_FFFF_9876_5432};
    vecs[5]  = '{4'b1000, 3'b110, 64'h1004, 64'h0, 64'h9876_5432_0000_0000, 64'h0, 64'h1000, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0000_0000_9876_5432};
    vecs[6]  = '{4'b1000, 3'b011, 64'h1008, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h1008, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[7]  = '{4'b0100, 3'b000, 64'h2005, 64'h1122_3344_5566_77AB, 64'h0, 64'h0, 64'h2000, 64'h6677_AB00_0000_0000, 8'h20, 1'b1, 1'b0, 64'h0};
    vecs[8]  = '{4'b0100, 3'b001, 64'h2006, 64'h0000_0000_0000_BEEF, 64'h0, 64'h0, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b1, 1'b0, 64'h0};
    vecs[9]  = '{4'b0100, 3'b010, 64'h2004, 64'h0000_0000_CAFE_F00D, 64'h0, 64'h0, 64'h2000, 64'hCAFE_F00D_0000_0000, 8'hF0, 1'b1, 1'b0, 64'h0};
    vecs[10] = '{4'b0100, 3'b011, 64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b0, 64'h0};
    vecs[11] = '{4'b0010, 3'b010, 64'h3004, 64'h5, 64'h8000_0001_0000_0000, 64'h0, 64'h3000, 64'h5, 8'hF0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0001};
    vecs[12] = '{4'b0010, 3'b011, 64'h3008, 64'h1234, 64'h7, 64'h0, 64'h3008, 64'h1234, 8'hFF, 1'b0, 1'b1, 64'h7};
    vecs[13] = '{4'b0000, 3'b000, 64'h42, 64'h0, 64'h0, 64'h5555, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0};
    vecs[14] = '{4'b0001, 3'b010, 64'h0, 64'h0, 64'h0, 64'hABCD, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'hABCD};

    // Reset with a memory op present: no request, MEM/WB at reset values
    reset = 1'b0; wb_stall = 1'b0; flush = 1'b0; csr_rdata = '0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_rdata = '0;
    drive(4'b1000, 3'b011, 64'h1000, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", dc_req_valid, 1'b0);
    chk1("rst_bubble", wb_is_bubble, 1'b1);
    chk("rst_inst", 64'(wb_inst), 64'h0);
    chk("rst_alu", wb_alu_result, 64'h0);
    chk("rst_mem", wb_mem_result, 64'h0);
    chk1("rst_mis", wb_misaligned, 1'b0);
    @(negedge clk);
    is_bubble = 1'b1;
    reset = 1'b1;

    // Zero-wait vector table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.kind, v.f3, v.addr, v.rs2);
      csr_rdata = v.csr; dc_req_ready = 1'b1; dc_resp_valid = 1'b0;
      #1;
      is_mem = |v.kind[3:1];
      chk1($sformatf("v%0d valid", i), dc_req_valid, is_mem);
      chk1($sformatf("v%0d stall0", i), stall, is_mem);
      if (is_mem) begin
        chk($sformatf("v%0d addr", i), dc_req_addr, v.e_addr);
        chk1($sformatf("v%0d we", i), dc_req_we, v.e_we);
        chk1($sformatf("v%0d amo", i), dc_req_amo, v.e_amo);
        if (v.kind[2] || v.kind[1]) begin
          chk($sformatf("v%0d wdata", i), dc_req_wdata, v.e_wdata);
          chk($sformatf("v%0d wstrb", i), 64'(dc_req_wstrb), 64'(v.e_wstrb));
        end
        @(negedge clk);
        dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_rdata = v.rdata;
        #1;
        chk1($sformatf("v%0d stall1", i), stall, 1'b0);
        chk1($sformatf("v%0d valid1", i), dc_req_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      dc_resp_valid = 1'b0;
      chk1($sformatf("v%0d wb_bubble", i), wb_is_bubble, 1'b0);
      chk($sformatf("v%0d wb_alu", i), wb_alu_result, v.addr);
      if (!v.kind[2]) chk($sformatf("v%0d wb_mem", i), wb_mem_result, v.e_mem);
    end

    // SH with ready delayed three cycles: request stable, stall high throughout
    @(negedge clk);
    drive(4'b0100, 3'b001, 64'h2006, 64'hBEEF);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      dc_req_ready = (c == 3);
      #1;
      chk1($sformatf("sh c%0d valid", c), dc_req_valid, 1'b1);
      chk($sformatf("sh c%0d addr", c), dc_req_addr, 64'h2000);
      chk($sformatf("sh c%0d wdata", c), dc_req_wdata, 64'hBEEF_0000_0000_0000);
      chk($sformatf("sh c%0d wstrb", c), 64'(dc_req_wstrb), 64'hC0);
      chk1($sformatf("sh c%0d stall", c), stall, 1'b1);
    end
    @(negedge clk);
    dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_rdata = '0;
    #1;
    chk1("sh wait_bubble", wb_is_bubble, 1'b1);
    chk1("sh stall_done", stall, 1'b0);
    @(posedge clk);
    #1;
    dc_resp_valid = 1'b0;
    chk1("sh wb_bubble", wb_is_bubble, 1'b0);
    chk("sh wb_alu", wb_alu_result, 64'h2006);

    // LD completing under WB back-pressure goes through the hold buffer
    @(negedge clk);
    drive(4'b1000, 3'b011, 64'h1010, 64'h0);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_rdata = 64'hFEDC_BA98_7654_3210; wb_stall = 1'b1;
    #1;
    chk1("hold stall1", stall, 1'b1);
    @(negedge clk);
    dc_resp_valid = 1'b0; dc_resp_rdata = '0;
    #1;
    chk1("hold no_dup", dc_req_valid, 1'b0);
    chk1("hold stall2", stall, 1'b1);
    @(negedge clk);
    wb_stall = 1'b0;
    #1;
    chk1("hold no_dup2", dc_req_valid, 1'b0);
    chk1("hold stall3", stall, 1'b0);
    @(posedge clk);
    #1;
    chk("hold wb_mem", wb_mem_result, 64'hFEDC_BA98_7654_3210);
    chk1("hold wb_bubble", wb_is_bubble, 1'b0);

    // Flush in RESP: response drained and discarded, next ADD flows normally
    @(negedge clk);
    drive(4'b1000, 3'b010, 64'h1000, 64'h0);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    chk1("flush wb_bubble1", wb_is_bubble, 1'b1);
    @(negedge clk);
    flush = 1'b0; is_bubble = 1'b1; dc_resp_valid = 1'b1; dc_resp_rdata = 64'h1234;
    #1;
    chk1("flush drain_stall", stall, 1'b1);
    chk1("flush drain_valid", dc_req_valid, 1'b0);
    @(posedge clk);
    #1;
    dc_resp_valid = 1'b0;
    chk1("flush wb_bubble2", wb_is_bubble, 1'b1);
    @(negedge clk);
    drive(4'b0000, 3'b000, 64'h99, 64'h0);
    #1;
    chk1("flush add_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    chk1("flush add_bubble", wb_is_bubble, 1'b0);
    chk("flush add_alu", wb_alu_result, 64'h99);

    // Reset asserted in REQ, then a stray response after release
    @(negedge clk);
    drive(4'b0000, 3'b000, 64'h77, 64'h0);
    @(negedge clk);
    drive(4'b1000, 3'b011, 64'h1000, 64'h0);
    wb_stall = 1'b1; dc_req_ready = 1'b0;
    @(negedge clk);
    #1;
    chk1("rreq valid_before", dc_req_valid, 1'b1);
    chk1("rreq frozen_bubble", wb_is_bubble, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rreq valid_reset", dc_req_valid, 1'b0);
    chk1("rreq bubble_reset", wb_is_bubble, 1'b1);
    chk("rreq alu_reset", wb_alu_result, 64'h0);
    @(negedge clk);
    reset = 1'b1; wb_stall = 1'b0; is_bubble = 1'b1;
    dc_resp_valid = 1'b1; dc_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk1("rreq stray_valid", dc_req_valid, 1'b0);
    chk1("rreq stray_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    dc_resp_valid = 1'b0;
    chk1("rreq stray_bubble", wb_is_bubble, 1'b1);
    @(negedge clk);
    drive(4'b0000, 3'b000, 64'h55, 64'h0);
    #1;
    chk1("rreq add_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    chk("rreq add_alu", wb_alu_result, 64'h55);
    chk1("rreq add_bubble", wb_is_bubble, 1'b0);

    // LW at a misaligned address
    @(negedge clk);
    drive(4'b1000, 3'b010, 64'h3002, 64'h0);
    dc_req_ready = 1'b1;
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    chk1("mis valid", dc_req_valid, 1'b0);
    chk1("mis stall", stall, 1'b0);
    @(posedge clk);
    #1;
    chk1("mis flag", wb_misaligned, 1'b1);
    chk1("mis en_rd", wb_inst.en_rd, 1'b0);
    chk1("mis bubble", wb_is_bubble, 1'b0);
`else
    chk1("mis valid", dc_req_valid, 1'b1);
    chk("mis addr", dc_req_addr, 64'h3000);
    @(negedge clk);
    dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_rdata = 64'h0000_8765_4321_0000;
    #1;
    chk1("mis stall", stall, 1'b0);
    @(posedge clk);
    #1;
    dc_resp_valid = 1'b0;
    chk1("mis flag", wb_misaligned, 1'b0);
    chk1("mis en_rd", wb_inst.en_rd, 1'b1);
    chk("mis mem", wb_mem_result, 64'hFFFF_FFFF_8765_4321);
`endif

    @(negedge clk);
    is_bubble = 1'b1;
    dc_req_ready = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
